// File: rtl/tmds_decoder_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder_aligner
//  Description : TMDS receive channel. Finds the 10-bit word boundary in a
//                deserialized stream by hunting for runs of control tokens,
//                then decodes aligned words into pixel data, control bits
//                and data enable, and reports lock status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder_aligner #(
    parameter int LOCK_RUN       = 32,
    parameter int MAINT_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 8192
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] tmds_raw,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de,
    output logic       locked,
    output logic [3:0] word_offset
);

    // Counter widths: the timeout counter is shared by both states, so it
    // is sized for the larger of the two limits.
    localparam int TMO_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX) + 1;
    localparam int RUN_W   = $clog2(LOCK_RUN) + 1;

    localparam logic [RUN_W-1:0] RUN_LOCK       = RUN_W'(LOCK_RUN);
    localparam logic [RUN_W-1:0] RUN_MAINT      = RUN_W'(MAINT_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE        = RUN_W'(1);
    localparam logic [TMO_W-1:0] TMO_SEARCH_END = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_LOSS_END   = TMO_W'(LOSS_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE        = TMO_W'(1);
    localparam logic [3:0]       OFFSET_LAST    = 4'd9;

    // The four DVI control tokens
    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Alignment path
    logic [9:0]  raw_prev;
    logic [19:0] window;
    logic [4:0]  sel;
    logic [9:0]  aligned;
    logic [9:0]  stage1;

    // Token detect / decode on the stage-1 word
    logic        is_token;
    logic [1:0]  token_ctrl;
    logic [7:0]  dec_data;

    // Alignment FSM
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [3:0]       offset;
    logic [3:0]       offset_nxt;
    logic [3:0]       offset_adv;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic [RUN_W-1:0] run_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic             lock_hit;
    logic             maint_event;

    // Stage-2 next values
    logic [7:0] data_nxt;
    logic [1:0] ctrl_nxt;
    logic       de_nxt;
    logic       locked_nxt;

    // Earlier bits sit in the lower half of the window, so a rising offset
    // slides the boundary later in the serial stream.
    assign window      = {tmds_raw, raw_prev};
    assign sel         = {1'b0, offset};
    assign aligned     = window[sel +: 10];
    assign word_offset = offset;

    // Previous raw word and stage-1 aligned word
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            raw_prev <= '0;
            stage1   <= '0;
        end else begin
            raw_prev <= tmds_raw;
            stage1   <= aligned;
        end
    end

    // Control token recognition on the stage-1 word
    always_comb begin
        is_token   = 1'b1;
        token_ctrl = 2'b00;
        case (stage1)
            TOK_C00: token_ctrl = 2'b00;
            TOK_C01: token_ctrl = 2'b01;
            TOK_C10: token_ctrl = 2'b10;
            TOK_C11: token_ctrl = 2'b11;
            default: is_token   = 1'b0;
        endcase
    end

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain
    always_comb begin
        logic [7:0] d;
        d        = stage1[9] ? ~stage1[7:0] : stage1[7:0];
        dec_data = '0;
        dec_data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = stage1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    // Alignment FSM state, offset and counters
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state   <= ST_SEARCH;
            offset  <= '0;
            run_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            offset  <= offset_nxt;
            run_cnt <= run_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Run counter saturates so a long blanking interval cannot wrap it
    assign run_inc     = is_token ? ((run_cnt == RUN_LOCK) ? run_cnt : run_cnt + RUN_ONE) : '0;
    assign lock_hit    = (run_inc == RUN_LOCK);
    // Any run of at least MAINT_RUN tokens keeps the lock fresh, so a long
    // blanking period refreshes continuously rather than once.
    assign maint_event = (run_inc >= RUN_MAINT);
    assign offset_adv  = (offset == OFFSET_LAST) ? 4'd0 : offset + 4'd1;

    // Next-state: lock acquisition, offset hunting and loss of lock
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        run_nxt    = run_inc;
        tmo_nxt    = tmo_cnt + TMO_ONE;
        case (state)
            ST_SEARCH: begin
                if (lock_hit) begin
                    state_nxt = ST_LOCKED;
                    tmo_nxt   = '0;
                end else if (tmo_cnt == TMO_SEARCH_END) begin
                    offset_nxt = offset_adv;
                    run_nxt    = '0;
                    tmo_nxt    = '0;
                end
            end
            ST_LOCKED: begin
                if (maint_event) begin
                    tmo_nxt = '0;
                end else if (tmo_cnt == TMO_LOSS_END) begin
                    state_nxt  = ST_SEARCH;
                    offset_nxt = offset_adv;
                    run_nxt    = '0;
                    tmo_nxt    = '0;
                end
            end
            default: begin
                state_nxt  = ST_SEARCH;
                offset_nxt = '0;
                run_nxt    = '0;
                tmo_nxt    = '0;
            end
        endcase
    end

    // Output selection: decode only while locked, hold the unused field
    always_comb begin
        data_nxt   = data_out;
        ctrl_nxt   = ctrl_out;
        de_nxt     = 1'b0;
        locked_nxt = (state == ST_LOCKED);
        if (state != ST_LOCKED) begin
            data_nxt = '0;
            ctrl_nxt = '0;
        end else if (is_token) begin
            ctrl_nxt = token_ctrl;
        end else begin
            de_nxt   = 1'b1;
            data_nxt = dec_data;
        end
    end

    // Stage-2 output register
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            data_out <= '0;
            ctrl_out <= '0;
            de       <= 1'b0;
            locked   <= 1'b0;
        end else begin
            data_out <= data_nxt;
            ctrl_out <= ctrl_nxt;
            de       <= de_nxt;
            locked   <= locked_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_decoder_aligner
//  Description : Self-checking bench for tmds_decoder_aligner. Directed
//                scenarios plus a randomized token/data stream compared
//                cycle by cycle against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder_aligner;

    localparam int LOCK_RUN       = 32;
    localparam int MAINT_RUN      = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int LOSS_TIMEOUT   = 128;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b0;
    logic [9:0] tmds_raw = '0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       locked;
    logic [3:0] word_offset;

    int n_cmp = 0;
    int n_bad = 0;

    tmds_decoder_aligner #(
        .LOCK_RUN       (LOCK_RUN),
        .MAINT_RUN      (MAINT_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_TIMEOUT   (LOSS_TIMEOUT)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .tmds_raw    (tmds_raw),
        .data_out    (data_out),
        .ctrl_out    (ctrl_out),
        .de          (de),
        .locked      (locked),
        .word_offset (word_offset)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int m_prev, m_s1, m_off, m_run, m_tmo;
    bit m_lock;
    int e_data, e_ctrl;
    bit e_de, e_locked;
    bit seen9;

    function automatic int tok_code(input int w);
        case (w)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int tmds_dec(input int w);
        int d, q, b;
        d = w & 255;
        if ((w & 512) != 0) d = d ^ 255;
        q = d & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((d >> i) ^ (d >> (i - 1))) & 1;
            if ((w & 256) == 0) b = 1 - b;
            q = q | (b << i);
        end
        return q;
    endfunction

    task automatic model_step(input int raw, input bit rst);
        int tc, run, nxt_s1;
        bit adv;
        if (rst) begin
            m_prev = 0; m_s1 = 0; m_off = 0; m_run = 0; m_tmo = 0; m_lock = 0;
            e_data = 0; e_ctrl = 0; e_de = 0; e_locked = 0;
            return;
        end
        tc       = tok_code(m_s1);
        e_locked = m_lock;
        if (m_lock) begin
            if (tc >= 0) begin e_de = 0; e_ctrl = tc; end
            else begin e_de = 1; e_data = tmds_dec(m_s1); end
        end else begin
            e_de = 0; e_data = 0; e_ctrl = 0;
        end
        nxt_s1 = (((raw << 10) | m_prev) >> m_off) & 1023;
        run    = (tc >= 0) ? m_run + 1 : 0;
        adv    = 0;
        if (!m_lock) begin
            if (run >= LOCK_RUN) begin m_lock = 1; m_tmo = 0; end
            else if (m_tmo == SEARCH_TIMEOUT - 1) adv = 1;
            else m_tmo++;
        end else begin
            if (run >= MAINT_RUN) m_tmo = 0;
            else if (m_tmo == LOSS_TIMEOUT - 1) begin m_lock = 0; adv = 1; end
            else m_tmo++;
        end
        if (adv) begin m_off = (m_off + 1) % 10; run = 0; m_tmo = 0; end
        m_run  = run;
        m_s1   = nxt_s1;
        m_prev = raw;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        n_cmp++;
        if (de !== e_de || data_out !== 8'(e_data) || ctrl_out !== 2'(e_ctrl) ||
            locked !== e_locked || word_offset !== 4'(m_off)) begin
            n_bad++;
            $display("FAIL model @%0t: got de=%0b data=%02h ctrl=%0d locked=%0b off=%0d, required de=%0b data=%02h ctrl=%0d locked=%0b off=%0d",
                     $time, de, data_out, ctrl_out, locked, word_offset,
                     e_de, 8'(e_data), e_ctrl, e_locked, m_off);
        end
    endtask

    task automatic tick(input logic [9:0] raw);
        tmds_raw = raw;
        @(posedge clk_pix);
        model_step(int'(raw), rst_pix);
        #1;
        check_model();
        if (word_offset == 4'd9) seen9 = 1'b1;
    endtask

    task automatic do_reset();
        rst_pix = 1'b1;
        tick(10'h000);
        rst_pix = 1'b0;
    endtask

    // Serial bit stream: words are appended LSB first, raw words are cut
    // from the front, so leading filler bits shift the word boundary.
    bit bq[$];

    task automatic start_stream(input int shift);
        bq.delete();
        for (int j = 0; j < shift; j++) bq.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic tick_stream(input logic [9:0] w);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) bq.push_back(w[j]);
        for (int j = 0; j < 10; j++) r[j] = bq.pop_front();
        tick(r);
    endtask

    task automatic stream_until_lock(input logic [9:0] w, input int bound, output bit got);
        got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            tick_stream(w);
            if (locked) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [9:0] rand_tok();
        case ($urandom_range(0, 3))
            0:       return 10'h354;
            1:       return 10'h0AB;
            2:       return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] r;
        r = 10'($urandom_range(0, 1023));
        if (tok_code(int'(r)) >= 0) r = r ^ 10'h001;
        return r;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0] raw;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    initial begin
        bit got;
        int cnt;
        bit any_lock;

        vecs[0]  = '{10'h100, 1'b1, 8'h00, 2'd0};
        vecs[1]  = '{10'h2FF, 1'b1, 8'hFE, 2'd0};
        vecs[2]  = '{10'h0AB, 1'b0, 8'hFE, 2'd1};
        vecs[3]  = '{10'h154, 1'b0, 8'hFE, 2'd2};
        vecs[4]  = '{10'h2AB, 1'b0, 8'hFE, 2'd3};
        vecs[5]  = '{10'h354, 1'b0, 8'hFE, 2'd0};
        vecs[6]  = '{10'h1FF, 1'b1, 8'h01, 2'd0};
        vecs[7]  = '{10'h0FF, 1'b1, 8'hFF, 2'd0};
        vecs[8]  = '{10'h2A0, 1'b1, 8'h1F, 2'd0};
        vecs[9]  = '{10'h13C, 1'b1, 8'h44, 2'd0};
        vecs[10] = '{10'h0AB, 1'b0, 8'h44, 2'd1};

        // ---- reset state ----
        do_reset();
        chk("reset_locked", int'(locked), 0);
        chk("reset_de", int'(de), 0);
        chk("reset_data", int'(data_out), 0);
        chk("reset_ctrl", int'(ctrl_out), 0);
        chk("reset_offset", int'(word_offset), 0);

        // ---- lock on 0x354 stream shifted by 3 bits ----
        start_stream(3);
        stream_until_lock(10'h354, 4 * SEARCH_TIMEOUT + LOCK_RUN + 2, got);
        chk("t1_lock_in_bound", int'(got), 1);
        chk("t1_offset", int'(word_offset), 3);
        chk("t1_ctrl", int'(ctrl_out), 0);
        chk("t1_de", int'(de), 0);
        for (int k = 0; k < 20; k++) tick_stream(10'h354);
        chk("t1_still_locked", int'(locked), 1);

        // ---- lock at offset 0, then table of data and control words ----
        do_reset();
        start_stream(0);
        stream_until_lock(10'h354, LOCK_RUN + 10, got);
        chk("t2_lock_off0", int'(got), 1);
        for (int k = 0; k < 40; k++) tick_stream(10'h354);
        for (int k = 0; k < NVEC + 2; k++) begin
            tick_stream((k < NVEC) ? vecs[k].raw : 10'h354);
            if (k >= 2) begin
                chk($sformatf("vec%0d_de", k - 2), int'(de), int'(vecs[k-2].de));
                chk($sformatf("vec%0d_data", k - 2), int'(data_out), int'(vecs[k-2].data));
                chk($sformatf("vec%0d_ctrl", k - 2), int'(ctrl_out), int'(vecs[k-2].ctrl));
            end
        end
        chk("t2_locked_offset", int'(word_offset), 0);

        // ---- loss of lock on data-only stream, then re-lock after wrap ----
        for (int k = 0; k < 140; k++) tick_stream(rand_data());
        chk("t4_unlocked", int'(locked), 0);
        chk("t4_offset1", int'(word_offset), 1);
        chk("t4_de0", int'(de), 0);
        chk("t4_data0", int'(data_out), 0);
        chk("t4_ctrl0", int'(ctrl_out), 0);
        seen9 = 1'b0;
        stream_until_lock(10'h354, 10 * SEARCH_TIMEOUT + LOCK_RUN + 10, got);
        chk("t4_relock", int'(got), 1);
        chk("t4_relock_off0", int'(word_offset), 0);
        chk("t4_wrapped_first", int'(seen9), 1);

        // ---- offset wrap 9 -> 0 and a 31-token run that must not lock ----
        do_reset();
        start_stream(0);
        got = 1'b0;
        for (int k = 0; k < 10 * SEARCH_TIMEOUT; k++) begin
            tick_stream(rand_data());
            if (word_offset == 4'd9) begin got = 1'b1; break; end
        end
        chk("t5_reach9", int'(got), 1);
        cnt = 0;
        got = 1'b0;
        for (int k = 0; k < SEARCH_TIMEOUT + 10; k++) begin
            tick_stream(rand_data());
            cnt++;
            if (word_offset == 4'd0) begin got = 1'b1; break; end
        end
        chk("t5_wrap_seen", int'(got), 1);
        chk("t5_wrap_cycles", cnt, SEARCH_TIMEOUT);
        any_lock = 1'b0;
        for (int k = 0; k < LOCK_RUN - 1; k++) begin
            tick_stream(10'h354);
            if (locked) any_lock = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            tick_stream(10'h100);
            if (locked) any_lock = 1'b1;
        end
        chk("t5_31run_nolock", int'(any_lock), 0);
        chk("t5_offset_kept", int'(word_offset), 0);

        // ---- reset asserted while locked at offset 5 ----
        do_reset();
        start_stream(5);
        stream_until_lock(10'h354, 6 * SEARCH_TIMEOUT + LOCK_RUN + 10, got);
        chk("t6_lock", int'(got), 1);
        chk("t6_offset5", int'(word_offset), 5);
        tick_stream(10'h2FF);
        for (int k = 0; k < 3; k++) tick_stream(10'h354);
        chk("t6_pre_data", int'(data_out), 'hFE);
        rst_pix = 1'b1;
        tick_stream(10'h354);
        rst_pix = 1'b0;
        chk("t6_locked0", int'(locked), 0);
        chk("t6_offset0", int'(word_offset), 0);
        chk("t6_de0", int'(de), 0);
        chk("t6_data0", int'(data_out), 0);

        // ---- randomized bursts against the model ----
        do_reset();
        start_stream($urandom_range(0, 9));
        cnt = 0;
        while (cnt < 3000) begin
            int nt, nd;
            nt = $urandom_range(0, 80);
            nd = $urandom_range(1, 40);
            for (int k = 0; k < nt; k++) begin tick_stream(rand_tok()); cnt++; end
            for (int k = 0; k < nd; k++) begin tick_stream(rand_data()); cnt++; end
            if (cnt > 1500 && cnt < 1600) begin
                for (int j = 0; j < int'($urandom_range(1, 9)); j++)
                    bq.push_back(1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
